// File: rtl/analog_spin_sampler.sv
// analog_spin_sampler: masked compute window, resync of analog spins, majority vote, valid/ready hand-off
module analog_spin_sampler #(
  parameter int NUM_SPIN = 256,
  parameter int SYNC_DEPTH_MAX = 3,
  parameter int NUM_SAMPLES_MAX = 7,
  parameter int COUNTER_BW = 16,
  localparam int SW = $clog2(SYNC_DEPTH_MAX + 1),
  localparam int NW = $clog2(NUM_SAMPLES_MAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [COUNTER_BW-1:0] cycle_per_spin_compute_i,
  input  logic [SW-1:0]         sync_stages_i,
  input  logic [NW-1:0]         sample_num_i,
  input  logic [NUM_SPIN-1:0]   spin_mask_i,
  input  logic [NUM_SPIN-1:0]   analog_spin_i,
  output logic [NUM_SPIN-1:0]   spin_compute_en_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [NUM_SPIN-1:0]   spin_o,
  output logic                  changed_o,
  output logic                  busy_o,
  output logic [COUNTER_BW-1:0] done_cnt_o
);
  typedef enum logic [2:0] {IDLE, COMPUTE, SETTLE, SAMPLE, HOLD} state_e;
  state_e state_q, state_d;
  logic [COUNTER_BW-1:0] cnt_q, cnt_d, c_eff, done_q;
  logic [SW-1:0] s_q, s_eff;
  logic [NW-1:0] n_q, n_lim, n_eff;
  logic [NUM_SPIN-1:0] mask_q, spin_q, spin_d, synced, vote;
  logic changed_q, changed_d;
  logic [SYNC_DEPTH_MAX-1:0][NUM_SPIN-1:0] sync_q;
  logic [NUM_SPIN-1:0][NW-1:0] ones_q, ones_d;
  logic accept, last, hs, hold_entry;

  assign c_eff = cycle_per_spin_compute_i == '0 ? COUNTER_BW'(1) : cycle_per_spin_compute_i;
  assign s_eff = sync_stages_i > SW'(SYNC_DEPTH_MAX) ? SW'(SYNC_DEPTH_MAX) : sync_stages_i;
  assign n_lim = sample_num_i > NW'(NUM_SAMPLES_MAX) ? NW'(NUM_SAMPLES_MAX) : sample_num_i;
  assign n_eff = n_lim == '0 ? NW'(1) : n_lim[0] ? n_lim : n_lim - NW'(1);
  assign accept = state_q == IDLE && start_i && en_i;
  assign last = cnt_q <= COUNTER_BW'(1);
  assign hs = state_q == HOLD && ready_i && en_i;
  assign hold_entry = state_q == SAMPLE && state_d == HOLD;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? COMPUTE : IDLE;
      COMPUTE: state_d = !last ? COMPUTE : s_q == '0 ? SAMPLE : SETTLE;
      SETTLE:  state_d = last ? SAMPLE : SETTLE;
      SAMPLE:  state_d = last ? HOLD : SAMPLE;
      HOLD:    state_d = ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    if (!en_i && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    spin_compute_en_o = state_q == COMPUTE ? mask_q : '0;
    valid_o = state_q == HOLD;
    busy_o = state_q != IDLE;
  end

  // Each phase reloads the shared down-counter with its own length on entry
  assign cnt_d = accept ? c_eff
               : (state_q == COMPUTE && state_d == SETTLE) ? COUNTER_BW'(s_q)
               : (state_q != SAMPLE && state_d == SAMPLE) ? COUNTER_BW'(n_q)
               : cnt_q - COUNTER_BW'(1);

  // The vote on the last sample edge includes that edge's bit, so spin_o is ready on HOLD entry
  always_comb begin
    synced = analog_spin_i;
    for (int j = 0; j < SYNC_DEPTH_MAX; j++)
      if (s_q == SW'(j + 1)) synced = sync_q[j];
    for (int i = 0; i < NUM_SPIN; i++) begin
      ones_d[i] = state_q == SAMPLE ? ones_q[i] + NW'(synced[i]) : '0;
      vote[i] = ones_d[i] > (n_q >> 1);
    end
    spin_d = hold_entry ? (vote & mask_q) | (spin_q & ~mask_q) : spin_q;
    changed_d = hold_entry ? |((vote ^ spin_q) & mask_q) : changed_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      s_q <= '0;
      n_q <= '0;
      mask_q <= '0;
      spin_q <= '0;
      changed_q <= 1'b0;
      done_q <= '0;
      sync_q <= '0;
      ones_q <= '0;
    end else begin
      sync_q[0] <= analog_spin_i;
      for (int j = 1; j < SYNC_DEPTH_MAX; j++) sync_q[j] <= sync_q[j-1];
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      spin_q <= spin_d;
      changed_q <= changed_d;
      if (hs) done_q <= done_q + COUNTER_BW'(1);
      if (accept) begin
        s_q <= s_eff;
        n_q <= n_eff;
        mask_q <= spin_mask_i;
      end
    end
  end

  assign spin_o = spin_q;
  assign changed_o = changed_q;
  assign done_cnt_o = done_q;
endmodule

// File: tb/tb_analog_spin_sampler.sv
// tb_analog_spin_sampler: table-driven, hand-written and randomized checks against a behavioural model
module tb_analog_spin_sampler;
  localparam int NS = 256;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, start, ready, valid, changed, busy;
  logic [15:0] cyc, done;
  logic [1:0] ss;
  logic [2:0] sn;
  logic [NS-1:0] mask, analog, sce, spin;

  analog_spin_sampler dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start),
    .cycle_per_spin_compute_i(cyc), .sync_stages_i(ss), .sample_num_i(sn),
    .spin_mask_i(mask), .analog_spin_i(analog), .spin_compute_en_o(sce),
    .valid_o(valid), .ready_i(ready), .spin_o(spin), .changed_o(changed),
    .busy_o(busy), .done_cnt_o(done)
  );

  logic w_start, w_ready, w_valid, w_changed, w_busy;
  logic [2:0] w_done;
  logic [7:0] w_sce, w_spin;

  analog_spin_sampler #(.NUM_SPIN(8), .COUNTER_BW(3)) wdut (
    .clk_i(clk), .rst_i(rst), .en_i(1'b1), .start_i(w_start),
    .cycle_per_spin_compute_i(3'd1), .sync_stages_i(2'd0), .sample_num_i(3'd1),
    .spin_mask_i(8'hFF), .analog_spin_i(8'h5A), .spin_compute_en_o(w_sce),
    .valid_o(w_valid), .ready_i(w_ready), .spin_o(w_spin), .changed_o(w_changed),
    .busy_o(w_busy), .done_cnt_o(w_done)
  );

  typedef struct {int c; int s; int n; int mk; int ak; int rd; int lat; int comp;} row_t;
  row_t tbl[8];
  int n_vec = 0, n_err = 0;
  logic [NS-1:0] av [0:63];
  logic [NS-1:0] m_spin = '0;
  int m_done = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int eff_c(int c); return c == 0 ? 1 : c; endfunction
  function automatic int eff_s(int s); return s > 3 ? 3 : s; endfunction
  function automatic int eff_n(int n);
    int k = n > 7 ? 7 : n;
    return k == 0 ? 1 : (k % 2 == 1 ? k : k - 1);
  endfunction

  function automatic logic [NS-1:0] rnd_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Sampled bits correspond to analog values at edges C+1..C+N after the start edge,
  // because the synchronizer delay and the settle wait are both S cycles.
  task automatic do_op(input int c, input int s, input int n, input logic [NS-1:0] mk,
                       input int rd, output int got_lat, output int comp);
    int ce, ne, t, ones;
    logic [NS-1:0] maj, exp_spin;
    logic exp_chg, bad_en, hold_bad;
    ce = eff_c(c);
    ne = eff_n(n);
    for (int b = 0; b < NS; b++) begin
      ones = 0;
      for (int j = 1; j <= ne; j++) ones += int'(av[ce+j][b]);
      maj[b] = ones > ne / 2;
    end
    exp_spin = (maj & mk) | (m_spin & ~mk);
    exp_chg = |((maj ^ m_spin) & mk);
    cyc = 16'(c); ss = 2'(s); sn = 3'(n); mask = mk;
    start = 1'b1; ready = rd == 0; analog = av[0];
    tick();
    start = 1'b0;
    cyc = 16'($urandom); ss = 2'($urandom); sn = 3'($urandom); mask = rnd_vec();
    t = 0; comp = 0; got_lat = -1; bad_en = 1'b0;
    while (got_lat < 0 && t < 200) begin
      if (sce === mk) comp++;
      else if (sce !== '0) bad_en = 1'b1;
      if (valid === 1'b1) got_lat = t + 1;
      else begin
        analog = av[t + 1 < 64 ? t + 1 : 63];
        tick();
        t++;
      end
    end
    chk("en_pattern", NS'(bad_en), '0);
    chk("spin", spin, exp_spin);
    chk("changed", NS'(changed), NS'(exp_chg));
    hold_bad = 1'b0;
    for (int i = 0; i < rd; i++) begin
      start = i == 3;
      tick();
      if (valid !== 1'b1 || busy !== 1'b1 || spin !== exp_spin || changed !== exp_chg) hold_bad = 1'b1;
    end
    start = 1'b0;
    if (rd > 0) chk("hold_stable", NS'(hold_bad), '0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("after_handshake", {valid, busy}, '0);
    m_done = (m_done + 1) % 65536;
    chk("done_cnt", NS'(done), NS'(m_done));
    m_spin = exp_spin;
  endtask

  initial begin
    int lat, comp, s, n, c;
    logic [NS-1:0] mk, x;
    tbl[0] = '{4, 2, 1, 0, 1, 10, 8, 4};
    tbl[1] = '{2, 0, 3, 1, 0, 0, 6, 2};
    tbl[2] = '{2, 0, 4, 1, 0, 2, 6, 2};
    tbl[3] = '{0, 1, 1, 0, 0, 1, 4, 1};
    tbl[4] = '{3, 3, 1, 1, 0, 0, 8, 3};
    tbl[5] = '{1, 2, 0, 1, 0, 3, 5, 1};
    tbl[6] = '{5, 1, 7, 1, 0, 0, 14, 5};
    tbl[7] = '{3, 3, 6, 0, 1, 4, 12, 3};
    rst = 1'b1; en = 1'b1; start = 1'b0; ready = 1'b0; cyc = '0; ss = '0; sn = '0;
    mask = '0; analog = '0; w_start = 1'b0; w_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_outs", {sce, spin, done, valid, changed, busy}, '0);

    foreach (tbl[r]) begin
      for (int j = 0; j < 64; j++) av[j] = tbl[r].ak == 1 ? {64{4'hA}} : rnd_vec();
      mk = tbl[r].mk == 0 ? '1 : rnd_vec();
      do_op(tbl[r].c, tbl[r].s, tbl[r].n, mk, tbl[r].rd, lat, comp);
      chk("tbl_latency", NS'(lat), NS'(tbl[r].lat));
      chk("tbl_compute", NS'(comp), NS'(tbl[r].comp));
    end

    for (int j = 0; j < 64; j++) av[j] = '0;
    av[3][0] = 1'b1; av[5][0] = 1'b1;
    do_op(2, 0, 3, '1, 0, lat, comp);
    chk("maj_101", NS'(spin[0]), NS'(1));
    av[3][0] = 1'b0; av[4][0] = 1'b1; av[5][0] = 1'b0;
    do_op(2, 0, 3, '1, 0, lat, comp);
    chk("maj_010", NS'(spin[0]), NS'(0));

    x = rnd_vec(); x[5] = 1'b0;
    for (int j = 0; j < 64; j++) av[j] = x;
    do_op(1, 1, 1, '1, 0, lat, comp);
    mk = '1; mk[5] = 1'b0;
    for (int j = 0; j < 64; j++) av[j] = x | (NS'(1) << 5);
    do_op(2, 1, 3, mk, 0, lat, comp);
    chk("mask_bit5", NS'(spin[5]), NS'(0));
    chk("mask_changed", NS'(changed), NS'(0));
    chk("mask_compute", NS'(comp), NS'(2));

    cyc = 16'd2; ss = 2'd1; sn = 3'd5; mask = '1; analog = rnd_vec(); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    en = 1'b0;
    tick();
    chk("abort_state", {valid, busy}, '0);
    chk("abort_spin", spin, m_spin);
    chk("abort_done", NS'(done), NS'(m_done));
    en = 1'b1;
    repeat (10) tick();
    chk("abort_novalid", {valid, busy}, '0);

    cyc = 16'd6; ss = 2'd2; sn = 3'd3; mask = '1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid", {sce, spin, done, valid, changed, busy}, '0);
    m_spin = '0; m_done = 0;

    for (int r = 0; r < 12; r++) begin
      c = $urandom_range(0, 6); s = $urandom_range(0, 3); n = $urandom_range(0, 7);
      for (int j = 0; j < 64; j++) av[j] = rnd_vec();
      do_op(c, s, n, rnd_vec(), $urandom_range(0, 4), lat, comp);
      chk("rnd_latency", NS'(lat), NS'(eff_c(c) + eff_s(s) + eff_n(n) + 1));
      chk("rnd_compute", NS'(comp), NS'(eff_c(c)));
    end

    for (int i = 1; i <= 9; i++) begin
      int k = 0;
      w_start = 1'b1;
      tick();
      w_start = 1'b0;
      while (w_valid !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      w_ready = 1'b1;
      tick();
      w_ready = 1'b0;
      chk("wrap_done", NS'(w_done), NS'(i % 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
